// File: rtl/aes_encrypt_core_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_encrypt_core_if : key / plaintext / ciphertext handshakes    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface aes_encrypt_core_if;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic [2:0]   key_len;
  logic         key_err;
  logic         keyed;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output key_valid, key, key_len, in_valid, plaintext, out_ready,
    input  key_ready, key_err, keyed, in_ready, out_valid, ciphertext
  );

  modport slave (
    input  key_valid, key, key_len, in_valid, plaintext, out_ready,
    output key_ready, key_err, keyed, in_ready, out_valid, ciphertext
  );
endinterface
`default_nettype wire

// File: rtl/aes_encrypt_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_encrypt_core : iterative AES-128/192/256, stored key schedule |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module aes_encrypt_core #(
  parameter int MAX_KEY_BITS = 256
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  aes_encrypt_core_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEXP  = 2'd1,
    S_KEYED = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [8:0] c_MAX_BITS = 9'(MAX_KEY_BITS);
  localparam logic [0:255][7:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {c_SBOX[w[31:24]], c_SBOX[w[23:16]], c_SBOX[w[15:8]], c_SBOX[w[7:0]]};
  endfunction

  // Swaps column-major (FIPS byte order) and row-major state layouts.
  function automatic logic [127:0] transpose(input logic [127:0] x);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = x[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    sb = '0;
    sr = '0;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = c_SBOX[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[127-8*(4*r+c) -: 8] = sb[127-8*(4*r+(c+r)%4) -: 8];
    mc = sr;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[127-8*c -: 8];
        a1 = sr[127-8*(4+c) -: 8];
        a2 = sr[127-8*(8+c) -: 8];
        a3 = sr[127-8*(12+c) -: 8];
        mc[127-8*c -: 8]      = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        mc[127-8*(4+c) -: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        mc[127-8*(8+c) -: 8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        mc[127-8*(12+c) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return mc ^ rk;
  endfunction

  state_t       r_fsm;
  logic [31:0]  r_w [0:59];
  logic [3:0]   r_nk, r_nr, r_round;
  logic [5:0]   r_widx;
  logic [2:0]   r_kmod;
  logic [7:0]   r_rcon;
  logic [127:0] r_state, r_ct;
  logic         r_out_valid, r_keyed, r_key_err;

  logic         w_key_acc, w_key_bad, w_blk_acc;
  logic [8:0]   w_kbits;
  logic [3:0]   w_nk;
  logic [31:0]  w_prev, w_temp, w_new;
  logic [5:0]   w_rk_base;
  logic [127:0] w_rk, w_round_out;

  assign bus.key_ready  = (r_fsm == S_IDLE || r_fsm == S_KEYED) && !r_out_valid;
  assign bus.in_ready   = (r_fsm == S_KEYED) && (!r_out_valid || bus.out_ready);
  assign bus.key_err    = r_key_err;
  assign bus.keyed      = r_keyed;
  assign bus.out_valid  = r_out_valid;
  assign bus.ciphertext = r_ct;

  always_comb begin
    w_kbits = 9'd0;
    w_nk    = 4'd0;
    if (bus.key_len[2]) begin
      w_kbits = 9'd256;
      w_nk    = 4'd8;
    end else if (bus.key_len[1]) begin
      w_kbits = 9'd192;
      w_nk    = 4'd6;
    end else if (bus.key_len[0]) begin
      w_kbits = 9'd128;
      w_nk    = 4'd4;
    end
  end

  assign w_key_bad = (w_kbits == 9'd0) || (w_kbits > c_MAX_BITS);
  assign w_key_acc = bus.key_valid && bus.key_ready;
  // A simultaneous key load takes precedence over a block in KEYED.
  assign w_blk_acc = bus.in_valid && bus.in_ready && !w_key_acc;

  always_comb begin
    w_prev = r_w[r_widx - 6'd1];
    w_temp = w_prev;
    if (r_kmod == 3'd0)
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'd0};
    else if (r_nk == 4'd8 && r_kmod == 3'd4)
      w_temp = sub_word(w_prev);
    w_new = r_w[r_widx - {2'b00, r_nk}] ^ w_temp;
  end

  assign w_rk_base   = (r_fsm == S_RUN) ? {r_round, 2'b00} : 6'd0;
  assign w_rk        = transpose({r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                                  r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]});
  assign w_round_out = aes_round(r_state, w_rk, r_round == r_nr);

  // Schedule storage is qualified by keyed, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_key_acc && !w_key_bad) begin
      for (int k = 0; k < 8; k++) r_w[k] <= bus.key[255-32*k -: 32];
    end else if (r_fsm == S_KEXP) begin
      r_w[r_widx] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= S_IDLE;
      r_nk        <= 4'd0;
      r_nr        <= 4'd0;
      r_round     <= 4'd0;
      r_widx      <= 6'd0;
      r_kmod      <= 3'd0;
      r_rcon      <= 8'h01;
      r_state     <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
      r_keyed     <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_key_err <= 1'b0;
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_key_acc) begin
        r_keyed <= 1'b0;
        if (w_key_bad) begin
          r_key_err <= 1'b1;
          r_fsm     <= S_IDLE;
        end else begin
          r_nk   <= w_nk;
          r_nr   <= w_nk + 4'd6;
          r_widx <= {2'b00, w_nk};
          r_kmod <= 3'd0;
          r_rcon <= 8'h01;
          r_fsm  <= S_KEXP;
        end
      end else begin
        case (r_fsm)
          S_KEXP: begin
            r_widx <= r_widx + 6'd1;
            r_kmod <= (r_kmod == r_nk[2:0] - 3'd1) ? 3'd0 : r_kmod + 3'd1;
            if (r_kmod == 3'd0) r_rcon <= xt(r_rcon);
            if (r_widx == {r_nr, 2'b11}) begin
              r_keyed <= 1'b1;
              r_fsm   <= S_KEYED;
            end
          end
          S_KEYED: begin
            if (w_blk_acc) begin
              r_state <= transpose(bus.plaintext) ^ w_rk;
              r_round <= 4'd1;
              r_fsm   <= S_RUN;
            end
          end
          S_RUN: begin
            r_state <= w_round_out;
            if (r_round == r_nr) begin
              r_ct        <= transpose(w_round_out);
              r_out_valid <= 1'b1;
              r_fsm       <= S_KEYED;
            end else begin
              r_round <= r_round + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_aes_encrypt_core : bench with byte-level FIPS-197 model       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_aes_encrypt_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aes_encrypt_core_if ifc ();
  aes_encrypt_core_if ifc1 ();

  aes_encrypt_core #(.MAX_KEY_BITS(256)) dut  (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));
  aes_encrypt_core #(.MAX_KEY_BITS(128)) dut1 (.clk(clk), .reset_n(reset_n), .bus(ifc1.slave));

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc_cnt = 0;
  logic [7:0]   sb [0:255];
  logic [127:0] expq [$];
  logic [255:0] cur_key;
  int           cur_nk;
  bit           rnd_bp = 1'b0;

  localparam logic [127:0] c_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] c_K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] c_K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] c_K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // FIPS-197 cipher on a column-major byte array (st[r+4c]).
  function automatic logic [127:0] model_enc(input logic [255:0] key, input int nk,
                                             input logic [127:0] pt);
    logic [31:0]  w [0:59];
    logic [7:0]   st [0:15];
    logic [7:0]   t  [0:15];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    int           nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r+4*c] = st[r+4*c] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = st[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) st[i] = t[i];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r+4*c] = gmul(8'h02, st[r+4*c]) ^ gmul(8'h03, st[(r+1)%4+4*c])
                       ^ st[(r+2)%4+4*c] ^ st[(r+3)%4+4*c];
        for (int i = 0; i < 16; i++) st[i] = t[i];
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[r+4*c] = st[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  // Scoreboard: expected results queue in acceptance order.
  always @(negedge clk) begin
    if (reset_n && ifc.in_valid && ifc.in_ready)
      expq.push_back(model_enc(cur_key, cur_nk, ifc.plaintext));
    if (reset_n && ifc.out_valid) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ct_unexpected: got %h expected no output", ifc.ciphertext);
      end else begin
        chk("ciphertext", ifc.ciphertext, expq[0]);
        if (ifc.out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) ifc.out_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic load_key(input logic [255:0] k, input logic [2:0] len, output int cyc);
    int n;
    ifc.key = k;
    ifc.key_len = len;
    ifc.key_valid = 1'b1;
    n = 0;
    while (!ifc.key_ready && n < 200) begin
      tick();
      n++;
    end
    chk_b("key_ready_wait", ifc.key_ready, 1'b1);
    tick();
    ifc.key_valid = 1'b0;
    cur_key = k;
    cur_nk = len[2] ? 8 : (len[1] ? 6 : 4);
    cyc = 0;
    while (!ifc.keyed && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send_block(input logic [127:0] pt, output int acc_cyc);
    int n;
    ifc.plaintext = pt;
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 200) begin
      tick();
      n++;
    end
    chk_b("in_ready_wait", ifc.in_ready, 1'b1);
    acc_cyc = cyc_cnt;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || ifc.out_valid) && n < 400) begin
      tick();
      n++;
    end
    chk_i("drain_queue", expq.size(), 0);
  endtask

  initial begin
    int           cyc, lat, a0, a1, sel;
    logic [127:0] ct0, pt;
    logic [255:0] k;
    logic [2:0]   len;
    logic [7:0]   inv, t, s;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      s = inv;
      t = inv;
      for (int j = 0; j < 4; j++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sb[x] = s ^ 8'h63;
    end
    chk("model128", model_enc(c_K128, 4, c_PT), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("model192", model_enc(c_K192, 6, c_PT), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("model256", model_enc(c_K256, 8, c_PT), 128'h8ea2b7ca516745bfeafc49904b496089);

    ifc.key_valid = 1'b0; ifc.key = '0; ifc.key_len = 3'b000;
    ifc.in_valid = 1'b0; ifc.plaintext = '0; ifc.out_ready = 1'b1;
    ifc1.key_valid = 1'b0; ifc1.key = '0; ifc1.key_len = 3'b000;
    ifc1.in_valid = 1'b0; ifc1.plaintext = '0; ifc1.out_ready = 1'b1;
    cur_key = '0;
    cur_nk = 4;
    tick();
    tick();
    chk_b("rst_key_ready", ifc.key_ready, 1'b1);
    chk_b("rst_in_ready", ifc.in_ready, 1'b0);
    chk_b("rst_out_valid", ifc.out_valid, 1'b0);
    chk_b("rst_keyed", ifc.keyed, 1'b0);
    chk_b("rst_key_err", ifc.key_err, 1'b0);
    chk("rst_ciphertext", ifc.ciphertext, 128'h0);
    reset_n = 1'b1;
    tick();

    load_key(c_K128, 3'b001, cyc);
    chk_i("kexp_cycles_128", cyc, 40);
    send_block(c_PT, a0);
    wait_out(lat);
    chk_i("latency_128", lat, 10);
    chk("fips_128", ifc.ciphertext, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();

    load_key(c_K192, 3'b010, cyc);
    chk_i("kexp_cycles_192", cyc, 46);
    send_block(c_PT, a0);
    wait_out(lat);
    chk_i("latency_192", lat, 12);
    chk("fips_192", ifc.ciphertext, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    tick();

    load_key(c_K256, 3'b100, cyc);
    chk_i("kexp_cycles_256", cyc, 52);
    send_block(c_PT, a0);
    wait_out(lat);
    chk_i("latency_256", lat, 14);
    chk("fips_256", ifc.ciphertext, 128'h8ea2b7ca516745bfeafc49904b496089);
    tick();

    // Back-pressure, then a second block accepted in the drain cycle.
    ifc.out_ready = 1'b0;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, a0);
    wait_out(lat);
    ct0 = ifc.ciphertext;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_b("bp_in_ready", ifc.in_ready, 1'b0);
      chk_b("bp_key_ready", ifc.key_ready, 1'b0);
      chk_b("bp_out_valid", ifc.out_valid, 1'b1);
      chk("bp_ct_stable", ifc.ciphertext, ct0);
    end
    ifc.out_ready = 1'b1;
    ifc.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    ifc.in_valid = 1'b1;
    #1;
    chk_b("drain_in_ready", ifc.in_ready, 1'b1);
    tick();
    ifc.in_valid = 1'b0;
    chk_b("drain_out_valid", ifc.out_valid, 1'b0);
    wait_out(lat);
    chk_i("latency_bp2", lat, 14);
    tick();

    // Invalid key_len on both DUTs; 256-bit on the 128-only instance.
    ifc.key_len = 3'b000;
    ifc.key_valid = 1'b1;
    ifc1.key_len = 3'b100;
    ifc1.key_valid = 1'b1;
    tick();
    ifc.key_valid = 1'b0;
    ifc1.key_valid = 1'b0;
    chk_b("err000_pulse", ifc.key_err, 1'b1);
    chk_b("err000_keyed", ifc.keyed, 1'b0);
    chk_b("errmax_pulse", ifc1.key_err, 1'b1);
    chk_b("errmax_keyed", ifc1.keyed, 1'b0);
    tick();
    chk_b("err000_end", ifc.key_err, 1'b0);
    chk_b("errmax_end", ifc1.key_err, 1'b0);
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_b("err000_in_ready", ifc.in_ready, 1'b0);
      chk_b("errmax_in_ready", ifc1.in_ready, 1'b0);
      tick();
    end
    ifc.in_valid = 1'b0;
    ifc1.key = c_K128;
    ifc1.key_len = 3'b001;
    ifc1.key_valid = 1'b1;
    tick();
    ifc1.key_valid = 1'b0;
    chk_b("max128_err", ifc1.key_err, 1'b0);
    for (int i = 0; i < 40; i++) tick();
    chk_b("max128_keyed", ifc1.keyed, 1'b1);

    // Reset in the middle of a 256-bit encryption.
    load_key(c_K256, 3'b100, cyc);
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, a0);
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0;
    #1;
    chk_b("mid_rst_out_valid", ifc.out_valid, 1'b0);
    chk_b("mid_rst_keyed", ifc.keyed, 1'b0);
    chk_b("mid_rst_key_ready", ifc.key_ready, 1'b1);
    chk_b("mid_rst_in_ready", ifc.in_ready, 1'b0);
    expq.delete();
    tick();
    reset_n = 1'b1;
    tick();
    chk_b("post_rst_in_ready", ifc.in_ready, 1'b0);
    load_key(c_K256, 3'b100, cyc);
    chk_i("reload_kexp_cycles", cyc, 52);
    send_block(c_PT, a0);
    wait_out(lat);
    chk("reload_fips_256", ifc.ciphertext, 128'h8ea2b7ca516745bfeafc49904b496089);
    tick();

    // Four back-to-back blocks under one 128-bit key.
    load_key({$urandom(), $urandom(), $urandom(), $urandom(), 128'h0}, 3'b001, cyc);
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, a0);
    for (int b = 1; b < 4; b++) begin
      send_block({$urandom(), $urandom(), $urandom(), $urandom()}, a1);
      chk_i("b2b_interval", a1 - a0, 11);
      a0 = a1;
    end
    drain();

    // Random keys, lengths and plaintexts under random back-pressure.
    rnd_bp = 1'b1;
    for (int kk = 0; kk < 4; kk++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      sel = $urandom_range(0, 2);
      len = (sel == 0) ? 3'b001 : (sel == 1) ? {2'b01, 1'($urandom_range(0, 1))}
                                             : {1'b1, 2'($urandom_range(0, 3))};
      load_key(k, len, cyc);
      chk_i("rnd_kexp_cycles", cyc, 4 * (cur_nk + 7) - cur_nk);
      for (int b = 0; b < 4; b++) begin
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(pt, a0);
      end
      drain();
    end
    rnd_bp = 1'b0;
    ifc.out_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
